// File: rtl/mem_resp_pkg.sv
// Shared definitions for the memory bus responder: size codes, FSM states
// and the alignment rule used when routing a request.
package mem_resp_pkg;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_READ  = 3'd2,
        ST_MERGE = 3'd3,
        ST_WRITE = 3'd4,
        ST_RESP  = 3'd5
    } state_t;

    // Size 2'b11 behaves as a word access, so size[1] alone selects word rules.
    function automatic logic misaligned(input logic [1:0] size, input logic [1:0] lane);
        if (size[1]) begin
            return lane != 2'b00;
        end else if (size == SZ_HALF) begin
            return lane[0];
        end else begin
            return 1'b0;
        end
    endfunction

endpackage

// File: rtl/mem_lane_merge.sv
// Combinational lane logic: little-endian extract with sign/zero extension
// for loads, and byte/half lane insertion for read-modify-write stores.
module mem_lane_merge
    import mem_resp_pkg::*;
(
    input  logic [31:0] word_i,
    input  logic [1:0]  size_i,
    input  logic [1:0]  lane_i,
    input  logic        unsigned_i,
    input  logic [31:0] wdata_i,
    output logic [31:0] load_o,
    output logic [31:0] merged_o
);

    logic [4:0]  byte_sh;
    logic [4:0]  half_sh;
    logic [31:0] byte_shifted;
    logic [31:0] half_shifted;
    logic [7:0]  byte_val;
    logic [15:0] half_val;

    assign byte_sh      = {lane_i, 3'b000};
    assign half_sh      = {lane_i[1], 4'b0000};
    assign byte_shifted = word_i >> byte_sh;
    assign half_shifted = word_i >> half_sh;
    assign byte_val     = byte_shifted[7:0];
    assign half_val     = half_shifted[15:0];

    always_comb begin
        load_o   = word_i;
        merged_o = wdata_i;
        case (size_i)
            SZ_BYTE: begin
                load_o   = unsigned_i ? {24'd0, byte_val} : {{24{byte_val[7]}}, byte_val};
                merged_o = (word_i & ~(32'h0000_00FF << byte_sh))
                         | ({24'd0, wdata_i[7:0]} << byte_sh);
            end
            SZ_HALF: begin
                load_o   = unsigned_i ? {16'd0, half_val} : {{16{half_val[15]}}, half_val};
                merged_o = (word_i & ~(32'h0000_FFFF << half_sh))
                         | ({16'd0, wdata_i[15:0]} << half_sh);
            end
            default: begin
                load_o   = word_i;
                merged_o = wdata_i;
            end
        endcase
    end

endmodule

// File: rtl/mem_bus_responder.sv
// Single-request memory responder with programmable wait latency, sub-word
// loads/stores (RMW) and misalignment flagging. Optional MEM_RANGE_CHECK_EN
// flags addresses beyond the array instead of letting them alias.
module mem_bus_responder
    import mem_resp_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req,
    input  logic        wr,
    input  logic [1:0]  size,
    input  logic        unsigned_ld,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        ready,
    output logic [31:0] rdata,
    output logic        addr_err
);

    localparam int         IDX_W     = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_INIT = 4'((WAIT_CYCLES > 0) ? WAIT_CYCLES - 1 : 0);

    state_t      state_q, state_d;
    logic [3:0]  wait_cnt_q, wait_cnt_d;
    logic        wr_q, wr_d;
    logic [1:0]  size_q, size_d;
    logic        uns_q, uns_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] wr_word_q, wr_word_d;
    logic        busy_q, busy_d;
    logic        ready_q, ready_d;
    logic [31:0] rdata_q, rdata_d;
    logic        addr_err_q, addr_err_d;

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] rd_word_q;
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;

    logic        sel_wr;
    logic [1:0]  sel_size;
    logic [31:0] sel_addr;
    logic [31:0] sel_wdata;
    logic        range_err;
    logic        sel_err;
    state_t      route_state;
    logic [31:0] load_data;
    logic [31:0] merged_word;

    // In IDLE the request is routed straight from the port when there is no wait stage.
    always_comb begin
        sel_wr    = wr_q;
        sel_size  = size_q;
        sel_addr  = addr_q;
        sel_wdata = wdata_q;
        if (state_q == ST_IDLE) begin
            sel_wr    = wr;
            sel_size  = size;
            sel_addr  = addr;
            sel_wdata = wdata;
        end
    end

`ifdef MEM_RANGE_CHECK_EN
    assign range_err = (sel_addr >> (IDX_W + 2)) != 32'd0;
`else
    logic unused_addr_hi;
    assign range_err      = 1'b0;
    assign unused_addr_hi = ^addr_q[31:IDX_W+2];
`endif

    assign sel_err = misaligned(sel_size, sel_addr[1:0]) | range_err;

    always_comb begin
        if (sel_err) begin
            route_state = ST_RESP;
        end else if (sel_wr && sel_size[1]) begin
            route_state = ST_WRITE;
        end else begin
            route_state = ST_READ;
        end
    end

    mem_lane_merge u_lane (
        .word_i     (rd_word_q),
        .size_i     (size_q),
        .lane_i     (addr_q[1:0]),
        .unsigned_i (uns_q),
        .wdata_i    (wdata_q),
        .load_o     (load_data),
        .merged_o   (merged_word)
    );

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        wr_d       = wr_q;
        size_d     = size_q;
        uns_d      = uns_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        wr_word_d  = wr_word_q;
        rdata_d    = rdata_q;
        addr_err_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (req) begin
                    wr_d    = wr;
                    size_d  = size;
                    uns_d   = unsigned_ld;
                    addr_d  = addr;
                    wdata_d = wdata;
                    if (WAIT_CYCLES == 0) begin
                        state_d    = route_state;
                        addr_err_d = sel_err;
                        wr_word_d  = sel_wdata;
                    end else begin
                        state_d    = ST_WAIT;
                        wait_cnt_d = WAIT_INIT;
                    end
                end
            end
            ST_WAIT: begin
                if (wait_cnt_q == 4'd0) begin
                    state_d    = route_state;
                    addr_err_d = sel_err;
                    wr_word_d  = sel_wdata;
                end else begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end
            ST_READ: begin
                if (wr_q) begin
                    state_d = ST_MERGE;
                end else begin
                    rdata_d = load_data;
                    state_d = ST_RESP;
                end
            end
            ST_MERGE: begin
                wr_word_d = merged_word;
                state_d   = ST_WRITE;
            end
            ST_WRITE: state_d = ST_RESP;
            ST_RESP:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
        busy_d  = state_d != ST_IDLE;
        ready_d = state_d == ST_RESP;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= 4'd0;
            wr_q       <= 1'b0;
            size_q     <= SZ_BYTE;
            uns_q      <= 1'b0;
            addr_q     <= 32'd0;
            wdata_q    <= 32'd0;
            wr_word_q  <= 32'd0;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
            rdata_q    <= 32'd0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            wr_q       <= wr_d;
            size_q     <= size_d;
            uns_q      <= uns_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            wr_word_q  <= wr_word_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
            rdata_q    <= rdata_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Read address tracks the port while idle so the word is ready even with no wait stage.
    assign rd_idx = (state_q == ST_IDLE) ? addr[IDX_W+1:2] : addr_q[IDX_W+1:2];
    assign wr_idx = addr_q[IDX_W+1:2];

    always_ff @(posedge clk) begin
        if (state_q == ST_WRITE) begin
            mem_q[wr_idx] <= wr_word_q;
        end
        rd_word_q <= mem_q[rd_idx];
    end

    assign busy     = busy_q;
    assign ready    = ready_q;
    assign rdata    = rdata_q;
    assign addr_err = addr_err_q;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Randomized bench with a byte-array reference model; a per-cycle compare
// process checks Busy/Ready/AddrErr/RData, plus literal pins for known cases.
module tb_mem_bus_responder;

    localparam int DEPTH = 256;
    localparam int W     = 1;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        wr = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        uns = 1'b0;
    logic [31:0] addr = 32'd0;
    logic [31:0] wdata = 32'd0;
    logic        busy, ready, addr_err;
    logic [31:0] rdata;

    always #5 clk = ~clk;

    mem_bus_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .wr          (wr),
        .size        (size),
        .unsigned_ld (uns),
        .addr        (addr),
        .wdata       (wdata),
        .busy        (busy),
        .ready       (ready),
        .rdata       (rdata),
        .addr_err    (addr_err)
    );

    int total = 0;
    int bad = 0;

    logic        exp_busy = 1'b0;
    logic        exp_ready = 1'b0;
    logic        exp_err = 1'b0;
    logic [31:0] exp_rdata = 32'd0;
    bit          chk_en = 1'b0;

    byte unsigned mb [DEPTH*4];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, got, want, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("busy", {31'd0, busy}, {31'd0, exp_busy});
            check("ready", {31'd0, ready}, {31'd0, exp_ready});
            check("addr_err", {31'd0, addr_err}, {31'd0, exp_err});
            check("rdata", rdata, exp_rdata);
        end
    end

    function automatic logic [31:0] model_load(input int a, input int nb, input logic u);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(mb[a+i]) << (8*i));
        if (!u && nb < 4 && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8*nb));
        return v;
    endfunction

    task automatic txn(input logic t_wr, input logic [1:0] t_size, input logic t_uns,
                       input logic [31:0] t_addr, input logic [31:0] t_wdata, input bit junk,
                       output logic [31:0] got_rd, output int got_lat, output logic got_err);
        int nb, len, a;
        logic err;
        nb  = (t_size == 2'b00) ? 1 : (t_size == 2'b01) ? 2 : 4;
        err = (nb == 4 && t_addr[1:0] != 2'b00) || (nb == 2 && t_addr[0]);
        a   = int'(t_addr[9:0]);
        len = err ? W + 1 : (t_wr && nb < 4) ? W + 4 : W + 2;
        got_lat = 0;
        got_rd  = 32'd0;
        got_err = 1'b0;
        @(negedge clk);
        req = 1'b1; wr = t_wr; size = t_size; uns = t_uns; addr = t_addr; wdata = t_wdata;
        @(posedge clk); #1;
        for (int k = 0; k < len; k++) begin
            exp_busy  = 1'b1;
            exp_ready = (k == len - 1);
            exp_err   = err && (k == len - 1);
            if (k == len - 1 && !err && !t_wr) exp_rdata = model_load(a, nb, t_uns);
            if (junk) begin
                req = 1'($urandom_range(0, 1)); wr = 1'($urandom); size = 2'($urandom);
                uns = 1'($urandom); addr = $urandom; wdata = $urandom;
            end else begin
                req = 1'b0;
            end
            @(negedge clk);
            if (ready && got_lat == 0) begin
                got_lat = k + 1;
                got_rd  = rdata;
                got_err = addr_err;
            end
            @(posedge clk); #1;
        end
        req = 1'b0;
        exp_busy = 1'b0; exp_ready = 1'b0; exp_err = 1'b0;
        if (!err && t_wr) begin
            for (int i = 0; i < nb; i++) mb[a+i] = t_wdata[8*i +: 8];
        end
        $display("txn wr=%0d size=%0d uns=%0d addr=%h wdata=%h -> lat=%0d err=%0d rdata=%h",
                 t_wr, t_size, t_uns, t_addr, t_wdata, got_lat, got_err, got_rd);
    endtask

    initial begin
        logic [31:0] r;
        int          lat;
        logic        e;
        logic [31:0] a;

        @(posedge clk); #1;
        chk_en = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #2 rst_n = 1'b1;

        for (int i = 0; i < 16; i++) txn(1'b1, 2'b10, 1'b0, 32'(i*4), $urandom, 1'b0, r, lat, e);

        txn(1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678, 1'b0, r, lat, e);
        check("st_word_lat", 32'(lat), 32'd3);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r, lat, e);
        check("ld_word_lat", 32'(lat), 32'd3);
        check("ld_word_val", r, 32'h1234_5678);
        check("ld_word_err", {31'd0, e}, 32'd0);

        txn(1'b1, 2'b00, 1'b0, 32'h11, 32'h0000_00AB, 1'b0, r, lat, e);
        check("st_byte_lat", 32'(lat), 32'd5);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r, lat, e);
        check("after_byte_st", r, 32'h1234_AB78);
        txn(1'b0, 2'b00, 1'b0, 32'h11, 32'h0, 1'b0, r, lat, e);
        check("ld_byte_sext", r, 32'hFFFF_FFAB);
        txn(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 1'b0, r, lat, e);
        check("ld_byte_zext", r, 32'h0000_00AB);

        txn(1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001, 1'b0, r, lat, e);
        txn(1'b0, 2'b01, 1'b0, 32'h12, 32'h0, 1'b0, r, lat, e);
        check("ld_half_sext", r, 32'hFFFF_8001);
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r, lat, e);
        check("after_half_st", r, 32'h8001_AB78);

        txn(1'b0, 2'b10, 1'b0, 32'h13, 32'h0, 1'b0, r, lat, e);
        check("misal_lat", 32'(lat), 32'd2);
        check("misal_err", {31'd0, e}, 32'd1);
        check("misal_keep", r, 32'h8001_AB78);
        txn(1'b1, 2'b10, 1'b0, 32'h02, 32'hDEAD_BEEF, 1'b0, r, lat, e);
        check("misal_st_err", {31'd0, e}, 32'd1);
        txn(1'b0, 2'b10, 1'b0, 32'h00, 32'h0, 1'b0, r, lat, e);

        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b1, r, lat, e);
        check("junk_lat", 32'(lat), 32'd3);
        txn(1'b0, 2'b10, 1'b0, 32'h410, 32'h0, 1'b0, r, lat, e);
        check("alias_ld", r, 32'h8001_AB78);

        // Reset in MERGE of a byte store must leave the target word untouched.
        @(negedge clk);
        req = 1'b1; wr = 1'b1; size = 2'b00; uns = 1'b0; addr = 32'h11; wdata = 32'h0000_00CD;
        @(posedge clk); #1;
        req = 1'b0; exp_busy = 1'b1; exp_ready = 1'b0; exp_err = 1'b0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        exp_busy = 1'b0; exp_rdata = 32'd0;
        rst_n = 1'b0;
        #1 check("rst_busy", {31'd0, busy}, 32'd0);
        @(negedge clk);
        #2 rst_n = 1'b1;
        $display("txn reset during merge at addr=00000011");
        txn(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 1'b0, r, lat, e);
        check("rst_no_write", r, 32'h8001_AB78);

        for (int n = 0; n < 300; n++) begin
            a = {22'd0, 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3))};
            a[9:8] = 2'b00;
            if ($urandom_range(0, 3) == 0) a[31:10] = 22'($urandom);
            txn(1'($urandom), 2'($urandom), 1'($urandom), a, $urandom, bit'($urandom_range(0, 1)),
                r, lat, e);
        end

        @(negedge clk);
        chk_en = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
